// File: rtl/ram_arbiter_if.sv
// Requester-side handshake for ram_arbiter: one read or write per req/ack pair.
interface ram_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
);
    logic              req;
    logic              wr;
    logic [ADDR_W-1:0] add;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (output req, wr, add, wdata, input ack, rdata);
    modport slave  (input req, wr, add, wdata, output ack, rdata);
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter/sequencer owning a registered single-port RAM.
// Index 0 of every internal pair is requester A, index 1 is requester B.
module ram_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    ram_arbiter_if.slave      port_a,
    ram_arbiter_if.slave      port_b,
    output logic [ADDR_W-1:0] ram_add,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_wr,
    input  logic [DATA_W-1:0] ram_data_out,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE} state_t;

    state_t                   state_q, state_d;
    logic                     last_q, last_d;
    logic                     gnt_q, gnt_d;
    logic [ADDR_W-1:0]        ram_add_q, ram_add_d;
    logic [DATA_W-1:0]        ram_data_in_q, ram_data_in_d;
    logic                     ram_wr_q, ram_wr_d;
    logic [1:0]               ack_q, ack_d;
    logic [1:0][DATA_W-1:0]   rdata_q, rdata_d;

    logic [1:0]               req, wr, elig;
    logic [1:0][ADDR_W-1:0]   add;
    logic [1:0][DATA_W-1:0]   wdata;
    logic                     win;

    assign req   = {port_b.req, port_a.req};
    assign wr    = {port_b.wr, port_a.wr};
    assign add   = {port_b.add, port_a.add};
    assign wdata = {port_b.wdata, port_a.wdata};

    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        gnt_d         = gnt_q;
        ram_add_d     = ram_add_q;
        ram_data_in_d = ram_data_in_q;
        ram_wr_d      = ram_wr_q;
        ack_d         = '0;
        rdata_d       = rdata_q;
        // A requester still holding req during its own ack cycle is not eligible.
        elig          = req & ~ack_q;
        win           = 1'b0;
        case (state_q)
            IDLE: begin
                if (|elig) begin
                    win           = (&elig) ? ~last_q : elig[1];
                    gnt_d         = win;
                    last_d        = win;
                    ram_add_d     = add[win];
                    ram_wr_d      = wr[win];
                    ram_data_in_d = wdata[win];
                    state_d       = ACCESS;
                end else begin
                    ram_wr_d = 1'b0;
                end
            end
            ACCESS: begin
                // ram_wr_q still holds the granted op here.
                ram_wr_d = 1'b0;
                if (ram_wr_q) begin
                    ack_d[gnt_q] = 1'b1;
                    state_d      = IDLE;
                end else begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                rdata_d[gnt_q] = ram_data_out;
                ack_d[gnt_q]   = 1'b1;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            last_q        <= 1'b1;
            gnt_q         <= 1'b0;
            ram_add_q     <= '0;
            ram_data_in_q <= '0;
            ram_wr_q      <= 1'b0;
            ack_q         <= '0;
            rdata_q       <= '0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            gnt_q         <= gnt_d;
            ram_add_q     <= ram_add_d;
            ram_data_in_q <= ram_data_in_d;
            ram_wr_q      <= ram_wr_d;
            ack_q         <= ack_d;
            rdata_q       <= rdata_d;
        end
    end

    assign port_a.ack   = ack_q[0];
    assign port_b.ack   = ack_q[1];
    assign port_a.rdata = rdata_q[0];
    assign port_b.rdata = rdata_q[1];
    assign ram_add      = ram_add_q;
    assign ram_data_in  = ram_data_in_q;
    assign ram_wr       = ram_wr_q;
    assign busy         = (state_q != IDLE);
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus random two-requester traffic
// checked against a serialized memory model and round-robin expectations.
module tb_ram_arbiter;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [ADDR_W-1:0] ram_add;
    logic [DATA_W-1:0] ram_data_in;
    logic [DATA_W-1:0] ram_data_out;
    logic              ram_wr;
    logic              busy;

    ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) pa ();
    ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) pb ();

    ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .port_a(pa), .port_b(pb),
        .ram_add(ram_add), .ram_data_in(ram_data_in), .ram_wr(ram_wr),
        .ram_data_out(ram_data_out), .busy(busy)
    );

    always #5 clk = ~clk;

    // Registered 1K x 8 RAM
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (ram_wr) mem[ram_add] <= ram_data_in;
        ram_data_out <= mem[ram_add];
    end

    int   n_cmp = 0;
    int   n_err = 0;
    int   wr_pulses = 0;
    bit   wr_long = 0;
    bit   ack_both = 0;
    logic wr_prev = 1'b0;

    always @(negedge clk) begin
        if (ram_wr && !wr_prev) wr_pulses++;
        if (ram_wr && wr_prev)  wr_long = 1;
        if (pa.ack && pb.ack)   ack_both = 1;
        wr_prev = ram_wr;
    end

    logic [DATA_W-1:0] exp_mem [16];
    bit                exp_vld [16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wr_pulses = 0;
        wr_long   = 0;
        ack_both  = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        clear_mon();
    endtask

    task automatic set_req(input bit side, input logic r, input logic w,
                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        if (side) begin pb.req = r; pb.wr = w; pb.add = a; pb.wdata = d; end
        else      begin pa.req = r; pa.wr = w; pa.add = a; pa.wdata = d; end
    endtask

    function automatic logic ack_of(input bit side);
        return side ? pb.ack : pa.ack;
    endfunction

    function automatic logic [DATA_W-1:0] rdata_of(input bit side);
        return side ? pb.rdata : pa.rdata;
    endfunction

    // Issues one request, holds it until ack (bounded), drops it in the ack cycle.
    task automatic run_access(input bit side, input logic w, input logic [ADDR_W-1:0] a,
                              input logic [DATA_W-1:0] d, output int lat,
                              output logic [DATA_W-1:0] rd);
        lat = 0;
        set_req(side, 1'b1, w, a, d);
        do begin tick(); lat++; end while (!ack_of(side) && lat < 10);
        rd = rdata_of(side);
        set_req(side, 1'b0, 1'b0, '0, '0);
        tick();
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        tick();
        n_cmp++; if ({pa.ack, pb.ack} !== 2'b00) begin n_err++; $display("FAIL reset_acks: got %b want 00", {pa.ack, pb.ack}); end
        n_cmp++; if (pa.rdata !== 8'h00) begin n_err++; $display("FAIL reset_rdata_a: got %h want 00", pa.rdata); end
        n_cmp++; if (pb.rdata !== 8'h00) begin n_err++; $display("FAIL reset_rdata_b: got %h want 00", pb.rdata); end
        n_cmp++; if (ram_wr !== 1'b0) begin n_err++; $display("FAIL reset_ram_wr: got %b want 0", ram_wr); end
        n_cmp++; if ({ram_add, ram_data_in} !== 18'h0) begin n_err++; $display("FAIL reset_ram_bus: got %h/%h want 0/0", ram_add, ram_data_in); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b0;
        tick();
        n_cmp++; if ({busy, pa.ack, pb.ack, ram_wr} !== 4'b0) begin n_err++; $display("FAIL reset_idle: got %b want 0000", {busy, pa.ack, pb.ack, ram_wr}); end
        clear_mon();
    endtask

    task automatic test_write_read();
        int lat;
        logic [DATA_W-1:0] rd;
        do_reset();
        run_access(1'b0, 1'b1, 10'h31D, 8'h33, lat, rd);
        n_cmp++; if (lat != 2) begin n_err++; $display("FAIL wr_latency: got %0d want 2", lat); end
        run_access(1'b0, 1'b0, 10'h31D, 8'h00, lat, rd);
        n_cmp++; if (lat != 3) begin n_err++; $display("FAIL rd_latency: got %0d want 3", lat); end
        n_cmp++; if (rd !== 8'h33) begin n_err++; $display("FAIL rd_data: got %h want 33", rd); end
        tick();
        n_cmp++; if (pa.rdata !== 8'h33) begin n_err++; $display("FAIL rdata_held: got %h want 33", pa.rdata); end
        n_cmp++; if (wr_pulses != 1) begin n_err++; $display("FAIL wr_pulse_count1: got %0d want 1", wr_pulses); end
    endtask

    task automatic test_tie();
        int cyc = 0, ca = 0, cb = 0;
        logic [DATA_W-1:0] rb = '0;
        do_reset();
        set_req(1'b0, 1'b1, 1'b1, 10'h3FD, 8'h3F);
        set_req(1'b1, 1'b1, 1'b0, 10'h3FD, 8'h00);
        while ((ca == 0 || cb == 0) && cyc < 16) begin
            tick(); cyc++;
            if (pa.ack) begin ca = cyc; set_req(1'b0, 1'b0, 1'b0, '0, '0); end
            if (pb.ack) begin cb = cyc; rb = pb.rdata; set_req(1'b1, 1'b0, 1'b0, '0, '0); end
        end
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        set_req(1'b1, 1'b0, 1'b0, '0, '0);
        n_cmp++; if (ca != 2) begin n_err++; $display("FAIL tie_ack_a_cycle: got %0d want 2", ca); end
        n_cmp++; if (cb != 5) begin n_err++; $display("FAIL tie_ack_b_cycle: got %0d want 5", cb); end
        n_cmp++; if (rb !== 8'h3F) begin n_err++; $display("FAIL tie_rdata_b: got %h want 3f", rb); end
        tick();
    endtask

    task automatic test_contention();
        int order[$];
        int na = 0, nb = 0, cyc = 0, last_cyc = 0;
        do_reset();
        set_req(1'b0, 1'b1, 1'b1, 10'h040, 8'hA0);
        set_req(1'b1, 1'b1, 1'b1, 10'h080, 8'hB0);
        while ((na < 8 || nb < 8) && cyc < 80) begin
            tick(); cyc++;
            if (pa.ack) begin
                order.push_back(0); na++; last_cyc = cyc;
                if (na < 8) set_req(1'b0, 1'b1, 1'b1, 10'(10'h040 + na), 8'(8'hA0 + na));
                else        set_req(1'b0, 1'b0, 1'b0, '0, '0);
            end
            if (pb.ack) begin
                order.push_back(1); nb++; last_cyc = cyc;
                if (nb < 8) set_req(1'b1, 1'b1, 1'b1, 10'(10'h080 + nb), 8'(8'hB0 + nb));
                else        set_req(1'b1, 1'b0, 1'b0, '0, '0);
            end
        end
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        set_req(1'b1, 1'b0, 1'b0, '0, '0);
        tick();
        n_cmp++; if (order.size() != 16) begin n_err++; $display("FAIL cont_ack_count: got %0d want 16", order.size()); end
        for (int i = 0; i < order.size(); i++) begin
            n_cmp++; if (order[i] != (i % 2)) begin n_err++; $display("FAIL cont_order[%0d]: got %0d want %0d", i, order[i], i % 2); end
        end
        n_cmp++; if (last_cyc != 32) begin n_err++; $display("FAIL cont_last_ack_cycle: got %0d want 32", last_cyc); end
        n_cmp++; if (wr_pulses != 16) begin n_err++; $display("FAIL cont_wr_pulses: got %0d want 16", wr_pulses); end
        n_cmp++; if (wr_long) begin n_err++; $display("FAIL cont_wr_width: got long pulse want 1-cycle"); end
        n_cmp++; if (ack_both) begin n_err++; $display("FAIL cont_ack_coincident: got both want exclusive"); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (mem[10'h040 + i] !== 8'(8'hA0 + i)) begin n_err++; $display("FAIL cont_mem_a[%0d]: got %h want %h", i, mem[10'h040 + i], 8'(8'hA0 + i)); end
            n_cmp++; if (mem[10'h080 + i] !== 8'(8'hB0 + i)) begin n_err++; $display("FAIL cont_mem_b[%0d]: got %h want %h", i, mem[10'h080 + i], 8'(8'hB0 + i)); end
        end
    endtask

    task automatic test_hold_req();
        int cyc = 0, acks = 0;
        do_reset();
        set_req(1'b0, 1'b1, 1'b1, 10'h123, 8'h77);
        do begin tick(); cyc++; end while (!pa.ack && cyc < 10);
        if (pa.ack) acks++;
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL hold_regrant: got busy=%b want 0", busy); end
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 4; i++) begin tick(); if (pa.ack) acks++; end
        n_cmp++; if (acks != 1) begin n_err++; $display("FAIL hold_acks: got %0d want 1", acks); end
        n_cmp++; if (wr_pulses != 1) begin n_err++; $display("FAIL hold_wr_pulses: got %0d want 1", wr_pulses); end
    endtask

    task automatic test_reset_mid_access();
        int lat, cyc = 0, stray = 0, first = -1;
        logic [DATA_W-1:0] rd;
        do_reset();
        run_access(1'b0, 1'b1, 10'h010, 8'h5A, lat, rd);
        run_access(1'b0, 1'b0, 10'h010, 8'h00, lat, rd);
        n_cmp++; if (rd !== 8'h5A) begin n_err++; $display("FAIL abort_pre_rdata: got %h want 5a", rd); end
        mem[10'h020] = 8'h00;
        set_req(1'b0, 1'b1, 1'b1, 10'h020, 8'hEE);
        tick();
        n_cmp++; if (ram_wr !== 1'b1) begin n_err++; $display("FAIL abort_in_access: got ram_wr=%b want 1", ram_wr); end
        rst = 1'b1;
        #1;
        n_cmp++; if (ram_wr !== 1'b0) begin n_err++; $display("FAIL abort_ram_wr: got %b want 0", ram_wr); end
        n_cmp++; if ({busy, pa.ack, pa.rdata, ram_add, ram_data_in} !== 29'h0) begin n_err++; $display("FAIL abort_outputs: got %h want 0", {busy, pa.ack, pa.rdata, ram_add, ram_data_in}); end
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        tick(); if (pa.ack) stray++;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin tick(); if (pa.ack) stray++; end
        n_cmp++; if (stray != 0) begin n_err++; $display("FAIL abort_no_ack: got %0d acks want 0", stray); end
        n_cmp++; if (mem[10'h020] !== 8'h00) begin n_err++; $display("FAIL abort_no_write: got %h want 00", mem[10'h020]); end
        set_req(1'b0, 1'b1, 1'b1, 10'h021, 8'h11);
        set_req(1'b1, 1'b1, 1'b1, 10'h022, 8'h22);
        while (first < 0 && cyc < 10) begin
            tick(); cyc++;
            if (pa.ack) first = 0;
            else if (pb.ack) first = 1;
        end
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        set_req(1'b1, 1'b0, 1'b0, '0, '0);
        n_cmp++; if (first != 0) begin n_err++; $display("FAIL abort_tie_winner: got %0d want 0 (A)", first); end
        repeat (4) tick();
    endtask

    task automatic test_boundary();
        int lat;
        logic [DATA_W-1:0] rd;
        do_reset();
        run_access(1'b0, 1'b1, 10'h3FF, 8'hAA, lat, rd);
        run_access(1'b0, 1'b1, 10'h000, 8'h55, lat, rd);
        run_access(1'b1, 1'b0, 10'h3FF, 8'h00, lat, rd);
        n_cmp++; if (rd !== 8'hAA) begin n_err++; $display("FAIL bound_3ff: got %h want aa", rd); end
        n_cmp++; if (lat != 3) begin n_err++; $display("FAIL bound_rd_latency: got %0d want 3", lat); end
        run_access(1'b1, 1'b0, 10'h000, 8'h00, lat, rd);
        n_cmp++; if (rd !== 8'h55) begin n_err++; $display("FAIL bound_000: got %h want 55", rd); end
    endtask

    task automatic rand_requester(input bit side);
        int gap, cyc, foreign;
        logic w;
        logic [3:0] idx;
        logic [DATA_W-1:0] d;
        for (int n = 0; n < 40; n++) begin
            gap = $urandom_range(0, 3);
            if (gap != 0) begin
                set_req(side, 1'b0, 1'b0, '0, '0);
                repeat (gap) tick();
            end
            w   = 1'($urandom_range(0, 1));
            idx = 4'($urandom_range(0, 15));
            d   = 8'($urandom);
            set_req(side, 1'b1, w, {6'h10, idx}, d);
            cyc = 0; foreign = 0;
            do begin
                tick(); cyc++;
                if (ack_of(!side)) foreign++;
            end while (!ack_of(side) && cyc < 20);
            n_cmp++;
            if (!ack_of(side)) begin
                n_err++; $display("FAIL rand_timeout side %0d op %0d: got no ack want ack", side, n);
            end else if (foreign > 1) begin
                n_err++; $display("FAIL rand_fairness side %0d op %0d: got %0d foreign want <=1", side, n, foreign);
            end
            if (ack_of(side)) begin
                if (w) begin
                    exp_mem[idx] = d; exp_vld[idx] = 1;
                end else if (exp_vld[idx]) begin
                    n_cmp++;
                    if (rdata_of(side) !== exp_mem[idx]) begin
                        n_err++; $display("FAIL rand_rdata side %0d addr %h: got %h want %h", side, {6'h10, idx}, rdata_of(side), exp_mem[idx]);
                    end
                end
            end
        end
        set_req(side, 1'b0, 1'b0, '0, '0);
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 16; i++) exp_vld[i] = 0;
        fork
            rand_requester(1'b0);
            rand_requester(1'b1);
        join
        n_cmp++; if (ack_both) begin n_err++; $display("FAIL rand_ack_coincident: got both want exclusive"); end
        n_cmp++; if (wr_long) begin n_err++; $display("FAIL rand_wr_width: got long pulse want 1-cycle"); end
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        set_req(1'b1, 1'b0, 1'b0, '0, '0);
        test_reset();
        test_write_read();
        test_tie();
        test_contention();
        test_hold_req();
        test_reset_mid_access();
        test_boundary();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
